// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: FSM encodings,
// access-size codes, byte-enable constants and lane helpers.
package mem_stage_lsu_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } acc_size_e;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_LANE0   = 4'b0001;

  function automatic logic misaligned(acc_size_e size, logic [1:0] off);
    case (size)
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Enable bit 3 always covers data bits [31:24]; endianness only moves the lane.
  function automatic logic [3:0] store_be(acc_size_e size, logic [1:0] off, logic big_endian);
    logic [1:0] lane;
    logic       hi;
    lane = big_endian ? (2'd3 - off) : off;
    hi   = big_endian ? ~off[1] : off[1];
    case (size)
      SZ_BYTE: return BE_LANE0 << lane;
      SZ_HALF: return hi ? BE_HI_HALF : BE_LO_HALF;
      default: return BE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Load-data lane select and zero/sign extension; purely combinational so it
// can be shared by other load paths.
module lsu_load_align
  import mem_stage_lsu_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [31:0] data_i,
  input  logic [1:0]  offset_i,
  input  acc_size_e   size_i,
  input  logic        sign_ext_i,
  output logic [31:0] data_o
);

  logic [1:0]  lane;
  logic        hi;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    lane   = BIG_ENDIAN ? (2'd3 - offset_i) : offset_i;
    hi     = BIG_ENDIAN ? ~offset_i[1] : offset_i[1];
    byte_v = data_i[{lane, 3'b000} +: 8];
    half_v = hi ? data_i[31:16] : data_i[15:0];
    case (size_i)
      SZ_BYTE: data_o = {{24{sign_ext_i & byte_v[7]}}, byte_v};
      SZ_HALF: data_o = {{16{sign_ext_i & half_v[15]}}, half_v};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: handshaked data-memory access, store lane
// replication, load alignment, memory stall and address-error generation.
//
// state | meaning
// IDLE  | no access outstanding; a new valid access is requested this cycle
// WAIT  | request outstanding, replayed from the registered copy until Ready
// DONE  | access complete, pipeline stalled; result held, no re-issue
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int ADDR_W     = 30,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              M_Flush,
  input  logic              M_Stall_In,
  input  logic              M_MemRead,
  input  logic              M_MemWrite,
  input  logic              M_MemByte,
  input  logic              M_MemHalf,
  input  logic              M_MemSignExtend,
  input  logic [31:0]       M_Address,
  input  logic [31:0]       M_WriteData,
  output logic [31:0]       M_ReadData,
  output logic              M_MemStall,
  output logic              M_AddrErr_L,
  output logic              M_AddrErr_S,
  input  logic [31:0]       DataMem_In,
  input  logic              DataMem_Ready,
  output logic              DataMem_Read,
  output logic [3:0]        DataMem_Write,
  output logic [ADDR_W-1:0] DataMem_Address,
  output logic [31:0]       DataMem_Out
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [31:0]       req_data_q, req_data_d;
  logic [3:0]        req_be_q, req_be_d;
  logic              req_rd_q, req_rd_d;
  acc_size_e         req_size_q, req_size_d;
  logic [1:0]        req_off_q, req_off_d;
  logic              req_sext_q, req_sext_d;
  logic              flushed_q, flushed_d;
  logic [31:0]       cap_q, cap_d;

  acc_size_e   size_in;
  logic        mis, is_load, is_store, valid;
  logic [31:0] wdata_rep;
  logic [3:0]  be_in;
  acc_size_e   al_size;
  logic [1:0]  al_off;
  logic        al_sext;
  logic [31:0] aligned;

  logic              rd_c, stall_c;
  logic [3:0]        we_c;
  logic [ADDR_W-1:0] addr_c;
  logic [31:0]       out_c, rdata_c;

  always_comb begin
    size_in  = M_MemByte ? SZ_BYTE : (M_MemHalf ? SZ_HALF : SZ_WORD);
    mis      = misaligned(size_in, M_Address[1:0]);
    is_store = M_MemWrite;
    is_load  = M_MemRead & ~M_MemWrite;
    valid    = (M_MemRead | M_MemWrite) & ~mis & ~M_Flush;
    be_in    = is_store ? store_be(size_in, M_Address[1:0], BIG_ENDIAN) : BE_NONE;
    case (size_in)
      SZ_BYTE: wdata_rep = {4{M_WriteData[7:0]}};
      SZ_HALF: wdata_rep = {2{M_WriteData[15:0]}};
      default: wdata_rep = M_WriteData;
    endcase
  end

  // In WAIT the pipeline inputs may already belong to a squashed instruction.
  always_comb begin
    if (state_q == ST_WAIT) begin
      al_size = req_size_q;
      al_off  = req_off_q;
      al_sext = req_sext_q;
    end else begin
      al_size = size_in;
      al_off  = M_Address[1:0];
      al_sext = M_MemSignExtend;
    end
  end

  lsu_load_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_load_align (
    .data_i    (DataMem_In),
    .offset_i  (al_off),
    .size_i    (al_size),
    .sign_ext_i(al_sext),
    .data_o    (aligned)
  );

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    req_be_d   = req_be_q;
    req_rd_d   = req_rd_q;
    req_size_d = req_size_q;
    req_off_d  = req_off_q;
    req_sext_d = req_sext_q;
    flushed_d  = flushed_q;
    cap_d      = cap_q;
    rd_c       = 1'b0;
    we_c       = BE_NONE;
    addr_c     = '0;
    out_c      = '0;
    rdata_c    = '0;
    stall_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid) begin
          rd_c   = is_load;
          we_c   = be_in;
          addr_c = M_Address[ADDR_W+1:2];
          out_c  = wdata_rep;
          if (DataMem_Ready) begin
            rdata_c = is_load ? aligned : 32'd0;
            cap_d   = rdata_c;
            state_d = M_Stall_In ? ST_DONE : ST_IDLE;
          end else begin
            stall_c    = 1'b1;
            state_d    = ST_WAIT;
            req_addr_d = M_Address[ADDR_W+1:2];
            req_data_d = wdata_rep;
            req_be_d   = be_in;
            req_rd_d   = is_load;
            req_size_d = size_in;
            req_off_d  = M_Address[1:0];
            req_sext_d = M_MemSignExtend;
            flushed_d  = 1'b0;
          end
        end
      end
      ST_WAIT: begin
        rd_c   = req_rd_q;
        we_c   = req_be_q;
        addr_c = req_addr_q;
        out_c  = req_data_q;
        if (DataMem_Ready) begin
          // Memory cannot abort, so a flushed access still completes but is dropped.
          if (flushed_q | M_Flush) begin
            state_d = ST_IDLE;
          end else begin
            rdata_c = req_rd_q ? aligned : 32'd0;
            cap_d   = rdata_c;
            state_d = M_Stall_In ? ST_DONE : ST_IDLE;
          end
        end else begin
          stall_c   = 1'b1;
          flushed_d = flushed_q | M_Flush;
        end
      end
      ST_DONE: begin
        rdata_c = cap_q;
        if (~M_Stall_In | M_Flush) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      req_addr_q <= '0;
      req_data_q <= '0;
      req_be_q   <= BE_NONE;
      req_rd_q   <= 1'b0;
      req_size_q <= SZ_WORD;
      req_off_q  <= 2'b00;
      req_sext_q <= 1'b0;
      flushed_q  <= 1'b0;
      cap_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      req_be_q   <= req_be_d;
      req_rd_q   <= req_rd_d;
      req_size_q <= req_size_d;
      req_off_q  <= req_off_d;
      req_sext_q <= req_sext_d;
      flushed_q  <= flushed_d;
      cap_q      <= cap_d;
    end
  end

  // Outputs are forced low while reset is asserted so a mid-access reset drops the request at once.
  assign DataMem_Read    = reset & rd_c;
  assign DataMem_Write   = reset ? we_c : BE_NONE;
  assign DataMem_Address = reset ? addr_c : '0;
  assign DataMem_Out     = reset ? out_c : '0;
  assign M_ReadData      = reset ? rdata_c : '0;
  assign M_MemStall      = reset & stall_c;
  assign M_AddrErr_L     = reset & is_load & mis & ~M_Flush;
  assign M_AddrErr_S     = reset & is_store & mis & ~M_Flush;

endmodule
